// File: rtl/biriscv_decode_fifo.sv
// biriscv_decode_fifo: fetch-to-decode instruction queue with flush and fault blocking
module biriscv_decode_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              fetch_valid_i,
    input  logic [31:0]       fetch_pc_i,
    input  logic [31:0]       fetch_instr_i,
    input  logic              fetch_fault_i,
    output logic              fetch_accept_o,
    output logic              decode_valid_o,
    output logic [31:0]       decode_pc_o,
    output logic [31:0]       decode_instr_o,
    output logic              decode_fault_o,
    input  logic              decode_accept_i,
    output logic [ADDR_W:0]   level_o
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_fault_block;
    logic [31:0]       r_pc    [DEPTH];
    logic [31:0]       r_instr [DEPTH];
    logic              r_fault [DEPTH];
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    // Handshakes and head-of-queue outputs; data is zeroed while empty so the decoder never sees stale words
    always_comb begin
        w_empty        = (r_count == '0);
        fetch_accept_o = ~rst_i & (r_count != FULL) & ~r_fault_block;
        decode_valid_o = ~w_empty & ~flush_i & ~rst_i;
        w_push         = fetch_valid_i & fetch_accept_o & ~flush_i;
        w_pop          = decode_valid_o & decode_accept_i;
        decode_pc_o    = w_empty ? 32'd0 : r_pc[r_rd_ptr];
        decode_instr_o = w_empty ? 32'd0 : r_instr[r_rd_ptr];
        decode_fault_o = w_empty ? 1'b0 : r_fault[r_rd_ptr];
        level_o        = r_count;
    end
    // Queue control state; reset and redirect both empty the queue and lift the fault block
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_fault_block <= 1'b0;
        end else begin
            r_wr_ptr      <= r_wr_ptr + ADDR_W'(w_push);
            r_rd_ptr      <= r_rd_ptr + ADDR_W'(w_pop);
            r_count       <= r_count + (ADDR_W + 1)'(w_push) - (ADDR_W + 1)'(w_pop);
            r_fault_block <= r_fault_block | (w_push & fetch_fault_i);
        end
    end
    // Entry storage, written only on an accepted push and never reset
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc[r_wr_ptr]    <= fetch_pc_i;
            r_instr[r_wr_ptr] <= fetch_instr_i;
            r_fault[r_wr_ptr] <= fetch_fault_i;
        end
    end
endmodule

// File: tb/tb_biriscv_decode_fifo.sv
// tb_biriscv_decode_fifo: directed checks of the decode instruction queue
module tb_biriscv_decode_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fv = 1'b0;
    logic [31:0] fpc = '0;
    logic [31:0] finstr = '0;
    logic        ffault = 1'b0;
    logic        facc;
    logic        dvalid;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic        dfault;
    logic        dacc = 1'b0;
    logic [2:0]  level;
    int          total = 0;
    int          bad = 0;

    biriscv_decode_fifo #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fetch_valid_i(fv), .fetch_pc_i(fpc), .fetch_instr_i(finstr), .fetch_fault_i(ffault),
        .fetch_accept_o(facc), .decode_valid_o(dvalid), .decode_pc_o(dpc),
        .decode_instr_o(dinstr), .decode_fault_o(dfault), .decode_accept_i(dacc),
        .level_o(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic fault);
        fv = 1'b1; fpc = pc; finstr = pc ^ 32'hDEAD0000; ffault = fault;
        tick();
        fv = 1'b0; ffault = 1'b0;
    endtask

    initial begin
        tick(); tick();
        settle();
        chk("rst_accept", 32'(facc), 0);
        chk("rst_valid", 32'(dvalid), 0);
        rst = 1'b0;
        settle();
        chk("post_rst_accept", 32'(facc), 1);
        chk("post_rst_valid", 32'(dvalid), 0);
        chk("post_rst_level", 32'(level), 0);

        // fill to full with decoder stalled, then drain in order
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 1'b0);
        settle();
        chk("fill_level", 32'(level), 4);
        chk("fill_accept", 32'(facc), 0);
        chk("fill_head_pc", dpc, 32'h100);
        chk("fill_head_instr", dinstr, 32'h100 ^ 32'hDEAD0000);
        dacc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_valid", 32'(dvalid), 1);
            chk("drain_pc", dpc, 32'h100 + 32'(4 * i));
            tick();
        end
        settle();
        chk("empty_valid", 32'(dvalid), 0);
        chk("empty_pc", dpc, 0);
        chk("empty_instr", dinstr, 0);
        chk("empty_fault", 32'(dfault), 0);
        chk("empty_level", 32'(level), 0);

        // streaming push and pop across pointer wrap
        for (int i = 0; i <= 10; i++) begin
            fv = (i < 10); fpc = 32'h200 + 32'(4 * i); finstr = fpc ^ 32'hDEAD0000;
            settle();
            if (i > 0) begin
                chk("stream_valid", 32'(dvalid), 1);
                chk("stream_pc", dpc, 32'h200 + 32'(4 * (i - 1)));
                chk("stream_level", 32'(level), 1);
            end
            tick();
        end
        fv = 1'b0; dacc = 1'b0;
        settle();
        chk("stream_end_level", 32'(level), 0);

        // pop while full does not enable a same-cycle push
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), 1'b0);
        fv = 1'b1; fpc = 32'h510; finstr = 32'h510 ^ 32'hDEAD0000; dacc = 1'b1;
        settle();
        chk("full_pop_accept", 32'(facc), 0);
        chk("full_pop_pc", dpc, 32'h500);
        tick();
        dacc = 1'b0;
        settle();
        chk("after_pop_level", 32'(level), 3);
        chk("after_pop_accept", 32'(facc), 1);
        tick();
        fv = 1'b0;
        settle();
        chk("refill_level", 32'(level), 4);
        dacc = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            chk("refill_drain_pc", dpc, 32'h500 + 32'(4 * i));
            tick();
        end
        dacc = 1'b0;

        // flush with concurrent push and pop at level 3
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(4 * i), 1'b0);
        flush = 1'b1; fv = 1'b1; fpc = 32'h300; dacc = 1'b1;
        settle();
        chk("flush_valid", 32'(dvalid), 0);
        chk("flush_accept_reads_high", 32'(facc), 1);
        tick();
        flush = 1'b0; fv = 1'b0; dacc = 1'b0;
        settle();
        chk("post_flush_level", 32'(level), 0);
        chk("post_flush_valid", 32'(dvalid), 0);
        chk("post_flush_pc", dpc, 0);
        tick();
        chk("post_flush_level2", 32'(level), 0);

        // faulting fetch blocks further pushes until redirect
        push(32'h400, 1'b0);
        fv = 1'b1; fpc = 32'h404; finstr = 32'h404 ^ 32'hDEAD0000; ffault = 1'b1;
        settle();
        chk("fault_push_accept", 32'(facc), 1);
        tick();
        ffault = 1'b0; fpc = 32'h408;
        settle();
        chk("blocked_accept", 32'(facc), 0);
        tick();
        fv = 1'b0;
        chk("blocked_level", 32'(level), 2);
        dacc = 1'b1;
        settle();
        chk("fault_head0_pc", dpc, 32'h400);
        chk("fault_head0_flag", 32'(dfault), 0);
        tick();
        chk("fault_head1_pc", dpc, 32'h404);
        chk("fault_head1_flag", 32'(dfault), 1);
        tick();
        dacc = 1'b0;
        chk("fault_drained_valid", 32'(dvalid), 0);
        chk("fault_still_blocked", 32'(facc), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("unblocked_accept", 32'(facc), 1);

        // reset with flush and push at level 2
        push(32'h700, 1'b0);
        push(32'h704, 1'b0);
        chk("pre_rst_level", 32'(level), 2);
        rst = 1'b1; flush = 1'b1; fv = 1'b1; fpc = 32'h708;
        settle();
        chk("mid_rst_accept", 32'(facc), 0);
        chk("mid_rst_valid", 32'(dvalid), 0);
        tick();
        rst = 1'b0; flush = 1'b0; fv = 1'b0;
        settle();
        chk("after_rst_level", 32'(level), 0);
        chk("after_rst_accept", 32'(facc), 1);
        chk("after_rst_valid", 32'(dvalid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
